mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 41 ++++
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_ctrl.sv | 114 +++++++++++
 tb/tb_mem_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and helpers for the byte-serial memory controller.
// Latency: none (pure definitions). Backpressure: not applicable.
// Holds the length codes, FSM encoding, the I/O address field and the load-extension helper.
package mem_ctrl_pkg;

    typedef logic [1:0] len_t;

    localparam len_t LEN_BYTE = 2'b00;
    localparam len_t LEN_HALF = 2'b01;
    localparam len_t LEN_WORD = 2'b10;

    // Address bits [17:16] equal to this value select the buffered I/O window.
    localparam logic [1:0] IO_FIELD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_RD,
        ST_RD_TAIL,
        ST_WR,
        ST_DONE
    } state_t;

    // Index of the final byte of an access: 0, 1 or 3 (code 11 behaves as a word).
    function automatic logic [1:0] last_idx(input len_t len);
        case (len)
            LEN_BYTE: return 2'd0;
            LEN_HALF: return 2'd1;
            default:  return 2'd3;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] raw, input len_t len, input logic sgn);
        case (len)
            LEN_BYTE: return {{24{sgn & raw[7]}}, raw[7:0]};
            LEN_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
            default:  return raw;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, data-access and RAM signals of the memory controller.
// Latency: none (wiring only). Backpressure: carried by if_stall_o and io_full_i.
// The controller connects through the slave modport, its environment through master.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_stall_o;

    logic        mem_req_i;
    logic        mem_we_i;
    len_t        mem_len_i;
    logic        mem_sign_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [31:0] mem_rdata_o;
    logic        mem_done_o;

    logic [31:0] ram_addr_o;
    logic        ram_wr_o;
    logic [7:0]  ram_data_o;
    logic [7:0]  ram_data_i;
    logic        io_full_i;

    modport slave (
        input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_sign_i,
               mem_addr_i, mem_wdata_i, ram_data_i, io_full_i,
        output if_stall_o, mem_rdata_o, mem_done_o, ram_addr_o, ram_wr_o, ram_data_o
    );

    modport master (
        output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i, mem_sign_i,
               mem_addr_i, mem_wdata_i, ram_data_i, io_full_i,
        input  if_stall_o, mem_rdata_o, mem_done_o, ram_addr_o, ram_wr_o, ram_data_o
    );

endinterface

// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM between instruction fetch and byte/half/word data accesses.
// Latency: load done in cycle n+2, store done in cycle n+1 after the request cycle.
// Backpressure: fetch stalled while a data access is active; MEM_CTRL_IO_EN holds I/O stores on io_full_i.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    mem_ctrl_if.slave  bus
);

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [31:0] addr_q, wdata_q, rbuf, rdata_q, merged, cur_addr;
    len_t        len_q;
    logic        sign_q, we_q, io_block;
    logic [1:0]  last_q;

    assign last_q   = last_idx(len_q);
    assign cur_addr = addr_q + {30'd0, cnt};

    // The fetch port never changes controller behaviour; the RAM address mux ignores if_req_i.
    logic unused_if;
    assign unused_if = bus.if_req_i;

`ifdef MEM_CTRL_IO_EN
    assign io_block = (cur_addr[17:16] == IO_FIELD) && bus.io_full_i;
`else
    logic unused_io;
    assign unused_io = bus.io_full_i;
    assign io_block  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Acceptance is decided in the IDLE cycle, so byte 0 issues on the very next cycle.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        bus.if_stall_o = 1'b1;
        bus.mem_done_o = 1'b0;
        bus.ram_addr_o = bus.if_addr_i;
        bus.ram_wr_o   = 1'b0;
        bus.ram_data_o = 8'h00;
        case (state)
            ST_IDLE: begin
                bus.if_stall_o = bus.mem_req_i;
                if (bus.mem_req_i) begin
                    state_nxt = bus.mem_we_i ? ST_WR : ST_RD;
                    cnt_nxt   = 2'd0;
                end
            end
            ST_ACCEPT: state_nxt = we_q ? ST_WR : ST_RD;
            ST_RD: begin
                bus.ram_addr_o = cur_addr;
                if (cnt == last_q) state_nxt = ST_RD_TAIL;
                else               cnt_nxt   = cnt + 2'd1;
            end
            ST_RD_TAIL: state_nxt = ST_DONE;
            ST_WR: begin
                bus.ram_addr_o = cur_addr;
                bus.ram_data_o = wdata_q[{cnt, 3'b000} +: 8];
                if (!io_block) begin
                    bus.ram_wr_o = 1'b1;
                    if (cnt == last_q) state_nxt = ST_DONE;
                    else               cnt_nxt   = cnt + 2'd1;
                end
            end
            ST_DONE: begin
                bus.mem_done_o = 1'b1;
                state_nxt      = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The last byte arrives during RD_TAIL and is merged straight into the result.
    always_comb begin
        merged = rbuf;
        merged[{last_q, 3'b000} +: 8] = bus.ram_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= 2'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            len_q   <= LEN_BYTE;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            rbuf    <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            cnt <= cnt_nxt;
            if (state == ST_IDLE && bus.mem_req_i) begin
                addr_q  <= bus.mem_addr_i;
                wdata_q <= bus.mem_wdata_i;
                len_q   <= bus.mem_len_i;
                sign_q  <= bus.mem_sign_i;
                we_q    <= bus.mem_we_i;
            end
            if (state == ST_RD && cnt != 2'd0)
                rbuf[{cnt - 2'd1, 3'b000} +: 8] <= bus.ram_data_i;
            if (state == ST_RD_TAIL)
                rdata_q <= extend(merged, len_q, sign_q);
        end
    end

    assign bus.mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed accesses push expected done/write events, monitors pop and compare.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    mem_ctrl_if bus();

    mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct { logic [31:0] rdata; int cyc; } done_exp_t;
    typedef struct { logic [31:0] addr; logic [7:0] dat; } wr_exp_t;

    done_exp_t   done_q[$];
    wr_exp_t     wr_q[$];
    done_exp_t   de;
    wr_exp_t     we_e;
    logic [7:0]  ram [logic [31:0]];
    logic [31:0] a_s;
    logic [7:0]  d_s;
    logic        w_s;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // RAM model: address sampled mid-cycle, read data valid the following cycle.
    always @(negedge clk) begin
        a_s = bus.ram_addr_o;
        w_s = bus.ram_wr_o;
        d_s = bus.ram_data_o;
    end

    always @(posedge clk) begin
        if (w_s === 1'b1) ram[a_s] = d_s;
        bus.ram_data_i <= ram.exists(a_s) ? ram[a_s] : 8'h00;
    end

    // Monitors
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.mem_done_o === 1'b1) begin
            if (done_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got pulse with rdata %h expected none (cycle %0d)", bus.mem_rdata_o, cyc);
            end else begin
                de = done_q.pop_front();
                check("done_cycle", 32'(cyc), 32'(de.cyc));
                check("rdata", bus.mem_rdata_o, de.rdata);
            end
        end
        if (rst === 1'b0 && bus.ram_wr_o === 1'b1) begin
            if (wr_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_write: got %h@%h expected none (cycle %0d)", bus.ram_data_o, bus.ram_addr_o, cyc);
            end else begin
                we_e = wr_q.pop_front();
                check("wr_addr", bus.ram_addr_o, we_e.addr);
                check("wr_data", {24'd0, bus.ram_data_o}, {24'd0, we_e.dat});
            end
        end
    end

    task automatic do_op(input logic we, input logic [1:0] len, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input bit chk_stall, input int io_hold);
        int        n;
        bit        seen;
        done_exp_t e;
        wr_exp_t   w;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        @(posedge clk); #1;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_len_i   = len;
        bus.mem_sign_i  = sgn;
        bus.mem_addr_i  = addr;
        bus.mem_wdata_i = wdata;
        if (io_hold > 0) bus.io_full_i = 1'b1;
        e.cyc   = cyc + (we ? n + 1 : n + 2) + (io_hold > 0 ? io_hold - 1 : 0);
        e.rdata = we ? last_rdata : exp_rd;
        if (!we) last_rdata = exp_rd;
        done_q.push_back(e);
        if (we) begin
            for (int k = 0; k < n; k++) begin
                w.addr = addr + k;
                w.dat  = wdata[8*k +: 8];
                wr_q.push_back(w);
            end
        end
        #1;
        if (chk_stall) check("stall_req_cycle", {31'd0, bus.if_stall_o}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (i < io_hold) begin
                check("io_hold_wr", {31'd0, bus.ram_wr_o}, 32'd0);
                if (i == io_hold - 1) bus.io_full_i = 1'b0;
            end
            if (chk_stall) check("stall_busy", {31'd0, bus.if_stall_o}, 32'd1);
            if (bus.mem_done_o === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got no done pulse expected one within 20 cycles (addr %h)", addr);
        end
        bus.mem_req_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst             = 1'b1;
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = 32'd0;
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_len_i   = 2'b00;
        bus.mem_sign_i  = 1'b0;
        bus.mem_addr_i  = 32'd0;
        bus.mem_wdata_i = 32'd0;
        bus.io_full_i   = 1'b0;
        ram[32'h200] = 8'h11;
        ram[32'h201] = 8'h22;
        ram[32'h202] = 8'h33;
        ram[32'h203] = 8'h84;
        ram[32'h010] = 8'h80;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_rdata", bus.mem_rdata_o, 32'd0);
        check("rst_done", {31'd0, bus.mem_done_o}, 32'd0);
        check("rst_wr", {31'd0, bus.ram_wr_o}, 32'd0);
        check("rst_wdata", {24'd0, bus.ram_data_o}, 32'd0);
        check("rst_stall", {31'd0, bus.if_stall_o}, 32'd0);

        // Fetch only
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h100;
        #1;
        check("fetch_addr", bus.ram_addr_o, 32'h100);
        check("fetch_stall", {31'd0, bus.if_stall_o}, 32'd0);
        bus.if_req_i = 1'b0;

        do_op(1'b0, 2'b10, 1'b1, 32'h200, 32'd0, 32'h84332211, 1'b0, 0);
        do_op(1'b0, 2'b00, 1'b1, 32'h010, 32'd0, 32'hFFFFFF80, 1'b0, 0);
        do_op(1'b0, 2'b00, 1'b0, 32'h010, 32'd0, 32'h00000080, 1'b0, 0);
        do_op(1'b1, 2'b01, 1'b0, 32'h0000FFFF, 32'h0000ABCD, 32'd0, 1'b0, 0);
        do_op(1'b0, 2'b01, 1'b1, 32'h0000FFFF, 32'd0, 32'hFFFFABCD, 1'b0, 0);
        do_op(1'b0, 2'b01, 1'b0, 32'h0000FFFF, 32'd0, 32'h0000ABCD, 1'b0, 0);
        do_op(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h12345678, 32'd0, 1'b0, 0);
        do_op(1'b0, 2'b10, 1'b1, 32'hFFFFFFFE, 32'd0, 32'h12345678, 1'b0, 0);
        do_op(1'b0, 2'b11, 1'b1, 32'h200, 32'd0, 32'h84332211, 1'b0, 0);
        do_op(1'b0, 2'b00, 1'b1, 32'h201, 32'd0, 32'h00000022, 1'b0, 0);

        // Fetch and data request in the same cycle
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h400;
        do_op(1'b0, 2'b00, 1'b0, 32'h010, 32'd0, 32'h00000080, 1'b1, 0);
        @(posedge clk); #1;
        check("fetch_resume_addr", bus.ram_addr_o, 32'h400);
        check("fetch_resume_stall", {31'd0, bus.if_stall_o}, 32'd0);
        bus.if_req_i = 1'b0;

`ifdef MEM_CTRL_IO_EN
        do_op(1'b1, 2'b00, 1'b0, 32'h00030000, 32'h0000005A, 32'd0, 1'b0, 3);
`else
        bus.io_full_i = 1'b1;
        do_op(1'b1, 2'b00, 1'b0, 32'h00030000, 32'h0000005A, 32'd0, 1'b0, 0);
        bus.io_full_i = 1'b0;
`endif

        // Reset in the middle of a word load
        @(posedge clk); #1;
        bus.mem_req_i  = 1'b1;
        bus.mem_we_i   = 1'b0;
        bus.mem_len_i  = 2'b10;
        bus.mem_sign_i = 1'b0;
        bus.mem_addr_i = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst           = 1'b1;
        bus.mem_req_i = 1'b0;
        @(posedge clk); #1;
        rst        = 1'b0;
        last_rdata = 32'd0;
        check("midrst_stall", {31'd0, bus.if_stall_o}, 32'd0);
        check("midrst_rdata", bus.mem_rdata_o, 32'd0);
        check("midrst_done", {31'd0, bus.mem_done_o}, 32'd0);
        check("midrst_addr", bus.ram_addr_o, bus.if_addr_i);
        repeat (10) @(posedge clk);

        do_op(1'b0, 2'b00, 1'b1, 32'h010, 32'd0, 32'hFFFFFF80, 1'b0, 0);

        repeat (4) @(posedge clk);
        check("done_queue_empty", 32'(done_q.size()), 32'd0);
        check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
